// File: rtl/input_capture_pkg.sv
// Shared definitions for the board-pin front end: FSM states and debounce defaults.
package input_capture_pkg;

  localparam int DEB_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/input_capture_debounce.sv
// Debouncer for an already-synchronized button: the level flips only after
// DEB_CYCLES consecutive cycles of disagreement; rise flags the cycle after a 0->1 flip.
module debounce
  import input_capture_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_lvl;
  logic             r_lvl_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_lvl_q <= 1'b0;
    end else begin
      r_lvl_q <= r_lvl;
      if (raw == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // Flip and clear together, so the counter never reaches its wrap point.
        r_lvl <= raw;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign lvl  = r_lvl;
  assign rise = r_lvl & ~r_lvl_q;

endmodule

// File: rtl/input_capture.sv
// Board-pin front end: synchronizes button and operand switches, debounces the
// button, and issues one Start pulse per press with the operand latched in N.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start_btn,
  input  logic [7:0] N_sw,
  input  logic       Done,
  output logic       Start,
  output logic [7:0] N,
  output logic       Ready
);

  logic [8:0] r_sync1;
  logic [8:0] r_sync2;
  logic       w_sync_btn;
  logic [7:0] w_sync_n;
  logic       w_lvl;
  logic       w_press;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_load;
  logic       r_start;
  logic       r_ready;
  logic [7:0] r_n;

  // Button in bit 8, operand in bits 7:0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {Start_btn, N_sw};
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_btn = r_sync2[8];
  assign w_sync_n   = r_sync2[7:0];

  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .raw  (w_sync_btn),
    .lvl  (w_lvl),
    .rise (w_press)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_load      = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH:  w_state_nxt = Done ? ST_RELEASE : ST_RUN;
      ST_RUN:     if (Done) w_state_nxt = ST_RELEASE;
      // Wait for the button to come up so a long hold cannot relaunch.
      ST_RELEASE: if (!w_lvl) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_ready <= 1'b1;
      r_n     <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_start <= (w_state_nxt == ST_LAUNCH);
      r_ready <= (w_state_nxt == ST_IDLE);
      if (w_load) r_n <= w_sync_n;
    end
  end

  assign Start = r_start;
  assign N     = r_n;
  assign Ready = r_ready;

endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture with DEB_CYCLES = 4: each press pushes the
// expected operand and launch cycle; a monitor checks every Start pulse against it.
module tb_input_capture;

  logic       clk;
  logic       Rst_n;
  logic       Start_btn;
  logic [7:0] N_sw;
  logic       Done;
  logic       Start;
  logic [7:0] N;
  logic       Ready;

  typedef struct {
    logic [7:0] n;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   nchk = 0;
  int   nerr = 0;

  input_capture #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .Clk      (clk),
    .Rst_n    (Rst_n),
    .Start_btn(Start_btn),
    .N_sw     (N_sw),
    .Done     (Done),
    .Start    (Start),
    .N        (N),
    .Ready    (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Start pulse must match the oldest expected launch.
  always @(negedge clk) begin
    if (Start === 1'b1) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL start_unexpected: Start at cycle %0d with N=%0d, none expected", cyc, N);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (N !== e.n || cyc != e.cyc) begin
          nerr++;
          $display("FAIL launch: got N=%0d at cycle %0d, expected N=%0d at cycle %0d",
                   N, cyc, e.n, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Clean rising edge now; launch lands 2 sync + 4 debounce + 1 FSM edges later.
  task automatic press(input logic [7:0] n);
    exp_t e;
    Start_btn = 1'b1;
    e.n   = n;
    e.cyc = cyc + 7;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL sb_timeout: %0d launches outstanding after %0d cycles", sb.size(), max);
      sb.delete();
    end
  endtask

  task automatic pulse_done();
    Done = 1'b1;
    tick(1);
    Done = 1'b0;
  endtask

  // Release the button; Ready must rise exactly 7 edges later.
  task automatic release_chk(input string nm);
    Start_btn = 1'b0;
    tick(6);
    chk({nm, "_ready_early"}, Ready, 0);
    tick(1);
    chk({nm, "_ready"}, Ready, 1);
  endtask

  initial begin
    Rst_n     = 1'b0;
    Start_btn = 1'b0;
    N_sw      = 8'h55;
    Done      = 1'b0;
    tick(3);
    chk("rst_start", Start, 0);
    chk("rst_n", N, 0);
    chk("rst_ready", Ready, 1);
    Rst_n = 1'b1;
    tick(1);
    chk("ready_after_rst", Ready, 1);

    // Done while idle is ignored
    pulse_done();
    tick(2);
    chk("idle_done_ready", Ready, 1);
    chk("idle_done_n", N, 0);

    // 3-cycle glitch is shorter than the debounce window
    Start_btn = 1'b1;
    tick(3);
    Start_btn = 1'b0;
    tick(12);
    chk("glitch_ready", Ready, 1);

    // Clean press, then hold through Done
    N_sw = 8'd97;
    tick(2);
    press(8'd97);
    wait_sb(20);
    chk("run_ready", Ready, 0);
    chk("n97", N, 97);
    pulse_done();
    tick(4);
    chk("held_ready", Ready, 0);
    release_chk("clean");

    // Bouncing button, operand lock during RUN
    N_sw = 8'd13;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      Start_btn = ~Start_btn;
      tick(2);
    end
    press(8'd13);
    wait_sb(20);
    N_sw = 8'd200;
    tick(5);
    chk("n_locked_run", N, 13);
    pulse_done();
    tick(2);
    chk("n_locked_release", N, 13);
    release_chk("bounce");
    chk("n_locked_idle", N, 13);

    tick(2);
    press(8'd200);
    wait_sb(20);
    chk("n200", N, 200);
    pulse_done();
    release_chk("second");

    // Done in the LAUNCH cycle goes straight to RELEASE
    N_sw = 8'd7;
    tick(2);
    press(8'd7);
    tick(7);
    chk("launch_start", Start, 1);
    pulse_done();
    chk("launch_done_ready", Ready, 0);
    release_chk("launch_done");

    // Reset during RUN with the button held, then relaunch
    N_sw = 8'h42;
    tick(2);
    press(8'h42);
    wait_sb(20);
    tick(2);
    Rst_n = 1'b0;
    tick(1);
    Rst_n = 1'b1;
    chk("midrst_start", Start, 0);
    chk("midrst_n", N, 0);
    chk("midrst_ready", Ready, 1);
    begin
      exp_t e;
      e.n   = 8'h42;
      e.cyc = cyc + 7;
      sb.push_back(e);
    end
    wait_sb(20);
    chk("relaunch_n", N, 8'h42);
    pulse_done();
    release_chk("relaunch");

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
